// File: rtl/mem_arbiter_if.sv
// Requester and memory-interpreter signal bundle for mem_arbiter.
// Latency: none (wiring only).
// Backpressure: none; the memory side uses a four-phase ren/wen/ack handshake.
interface mem_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int GID_W   = 2
);
    // requester side
    logic [NUM_REQ-1:0]    req_ren;
    logic [NUM_REQ-1:0]    req_wen;
    logic [NUM_REQ-1:0]    req_lock;
    logic [32*NUM_REQ-1:0] req_addr;
    logic [32*NUM_REQ-1:0] req_wdata;
    logic [NUM_REQ-1:0]    req_ack;
    logic                  req_err;
    logic [31:0]           req_rdata;
    logic [GID_W-1:0]      grant_id;
    logic                  busy;
    // memory interpreter side
    logic [31:0]           mem_addr;
    logic [31:0]           mem_data_i;
    logic                  mem_ren;
    logic                  mem_wen;
    logic                  mem_ack;
    logic [31:0]           mem_data_o;

    // arbiter view
    modport slave (
        input  req_ren, req_wen, req_lock, req_addr, req_wdata, mem_ack, mem_data_o,
        output req_ack, req_err, req_rdata, grant_id, busy,
               mem_addr, mem_data_i, mem_ren, mem_wen
    );

    // requesters plus interpreter view
    modport master (
        output req_ren, req_wen, req_lock, req_addr, req_wdata, mem_ack, mem_data_o,
        input  req_ack, req_err, req_rdata, grant_id, busy,
               mem_addr, mem_data_i, mem_ren, mem_wen
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory interpreter port among NUM_REQ requesters (optional grant lock: MEM_ARB_LOCK_EN).
// Latency: request seen in IDLE -> registered mem_ren/mem_wen on the next edge; req_ack one edge after mem_ack.
// Backpressure: one transaction at a time; others wait at level until the arbiter is back in IDLE; watchdog aborts.
module mem_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int TIMEOUT = 255,
    parameter int GID_W   = 2
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave arb
);

    localparam int OFF_W = $clog2(32*NUM_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;

    state_t               state, state_nx;
    logic [GID_W-1:0]     last_grant, last_grant_nx;
    logic [GID_W-1:0]     grant_id, grant_id_nx;
    logic [7:0]           wdog, wdog_nx;
    logic [31:0]          mem_addr_r, mem_addr_nx;
    logic [31:0]          mem_data_r, mem_data_nx;
    logic                 mem_ren_r, mem_ren_nx;
    logic                 mem_wen_r, mem_wen_nx;
    logic [31:0]          rdata_r, rdata_nx;
    logic [NUM_REQ-1:0]   ack_r, ack_nx;
    logic                 err_r, err_nx;

    logic [NUM_REQ-1:0]   pending;
    logic                 rr_found;
    logic [GID_W-1:0]     rr_winner;
    logic                 lock_hold;
    logic                 lock_txn;
    logic                 lock_use;
    logic                 win_found;
    logic [GID_W-1:0]     winner;
    logic [OFF_W-1:0]     win_off;

    assign pending = arb.req_ren | arb.req_wen;

    // Round-robin search: first pending requester after last_grant, wrapping
    always_comb begin : rr_search
        int idx;
        idx       = 0;
        rr_found  = 1'b0;
        rr_winner = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!rr_found && pending[idx[GID_W-1:0]]) begin
                rr_found  = 1'b1;
                rr_winner = idx[GID_W-1:0];
            end
        end
    end

    // A held lock overrides round-robin only while its owner is still pending
    assign lock_use  = lock_hold & pending[grant_id];
    assign win_found = lock_use | rr_found;
    assign winner    = lock_use ? grant_id : rr_winner;
    assign win_off   = OFF_W'(winner) << 5;

`ifdef MEM_ARB_LOCK_EN
    // Lock state: armed at RELEASE exit from the finishing requester's req_lock, dropped in IDLE once its owner goes quiet
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_hold <= 1'b0;
            lock_txn  <= 1'b0;
        end else begin
            if (state == RELEASE && !arb.mem_ack)
                lock_hold <= arb.req_lock[grant_id];
            else if (state == IDLE && !lock_use)
                lock_hold <= 1'b0;
            if (state == IDLE && win_found)
                lock_txn <= lock_use;
        end
    end
`else
    logic unused_lock;
    assign lock_hold   = 1'b0;
    assign lock_txn    = 1'b0;
    assign unused_lock = ^arb.req_lock;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state and registered-output decode for IDLE / ISSUE / RELEASE
    always_comb begin
        state_nx      = state;
        last_grant_nx = last_grant;
        grant_id_nx   = grant_id;
        wdog_nx       = wdog;
        mem_addr_nx   = mem_addr_r;
        mem_data_nx   = mem_data_r;
        mem_ren_nx    = mem_ren_r;
        mem_wen_nx    = mem_wen_r;
        rdata_nx      = rdata_r;
        ack_nx        = '0;
        err_nx        = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_nx    = ISSUE;
                    mem_addr_nx = arb.req_addr[win_off +: 32];
                    mem_data_nx = arb.req_wdata[win_off +: 32];
                    // read takes precedence when both strobes are set
                    mem_ren_nx  = arb.req_ren[winner];
                    mem_wen_nx  = arb.req_wen[winner] & ~arb.req_ren[winner];
                    grant_id_nx = winner;
                    wdog_nx     = '0;
                end
            end
            ISSUE: begin
                // wdog holds the number of ISSUE cycles already spent without ack
                wdog_nx = 8'(wdog + 8'd1);
                if (arb.mem_ack) begin
                    rdata_nx   = arb.mem_data_o;
                    ack_nx     = NUM_REQ'(1) << grant_id;
                    mem_ren_nx = 1'b0;
                    mem_wen_nx = 1'b0;
                    state_nx   = RELEASE;
                end else if (wdog == 8'(TIMEOUT)) begin
                    rdata_nx   = '0;
                    ack_nx     = NUM_REQ'(1) << grant_id;
                    err_nx     = 1'b1;
                    mem_ren_nx = 1'b0;
                    mem_wen_nx = 1'b0;
                    state_nx   = RELEASE;
                end
            end
            RELEASE: begin
                // complete the four-phase handshake before the next grant
                if (!arb.mem_ack) begin
                    if (!lock_txn) last_grant_nx = grant_id;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath registers; reset drops the memory strobes immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= GID_W'(NUM_REQ - 1);
            grant_id   <= '0;
            wdog       <= '0;
            mem_addr_r <= '0;
            mem_data_r <= '0;
            mem_ren_r  <= 1'b0;
            mem_wen_r  <= 1'b0;
            rdata_r    <= '0;
            ack_r      <= '0;
            err_r      <= 1'b0;
        end else begin
            last_grant <= last_grant_nx;
            grant_id   <= grant_id_nx;
            wdog       <= wdog_nx;
            mem_addr_r <= mem_addr_nx;
            mem_data_r <= mem_data_nx;
            mem_ren_r  <= mem_ren_nx;
            mem_wen_r  <= mem_wen_nx;
            rdata_r    <= rdata_nx;
            ack_r      <= ack_nx;
            err_r      <= err_nx;
        end
    end

    assign arb.mem_addr   = mem_addr_r;
    assign arb.mem_data_i = mem_data_r;
    assign arb.mem_ren    = mem_ren_r;
    assign arb.mem_wen    = mem_wen_r;
    assign arb.req_rdata  = rdata_r;
    assign arb.req_ack    = ack_r;
    assign arb.req_err    = err_r;
    assign arb.grant_id   = grant_id;
    assign arb.busy       = (state == ISSUE) || (state == RELEASE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: single read, round-robin, read priority, timeout, async reset, lock bursts.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: the bench plays the memory interpreter, controlling mem_ack per transaction.
module tb_mem_arbiter;

    localparam int NUM_REQ = 3;
    localparam int GID_W   = 2;
    localparam int TIMEOUT = 255;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [31:0] addr_q  [NUM_REQ];
    logic [31:0] wdata_q [NUM_REQ];

    always #5 clk = ~clk;

    mem_arbiter_if #(.NUM_REQ(NUM_REQ), .GID_W(GID_W)) bus ();

    assign bus.req_addr  = {addr_q[2], addr_q[1], addr_q[0]};
    assign bus.req_wdata = {wdata_q[2], wdata_q[1], wdata_q[0]};

    mem_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT), .GID_W(GID_W)) dut (
        .clk (clk),
        .rst (rst),
        .arb (bus.slave)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_req(input logic [1:0] i, input logic [31:0] a, input logic [31:0] d);
        addr_q[i]  = a;
        wdata_q[i] = d;
    endtask

    task automatic clear_inputs();
        bus.req_ren    = '0;
        bus.req_wen    = '0;
        bus.req_lock   = '0;
        bus.mem_ack    = 1'b0;
        bus.mem_data_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_q[i]  = '0;
            wdata_q[i] = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic wait_strobe(input int max_cyc, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < max_cyc) begin
            if (bus.mem_ren || bus.mem_wen) ok = 1'b1;
            else begin
                tick();
                n++;
            end
        end
    endtask

    // Interpreter ack for the transaction in ISSUE; returns the req_ack seen on the
    // pulse cycle and on the cycle after, and leaves the arbiter back in IDLE.
    task automatic complete(input logic [31:0] rd, input logic [2:0] drop_mask,
                            output logic [2:0] ack_seen, output logic err_seen,
                            output logic [2:0] ack_next);
        bus.mem_data_o = rd;
        bus.mem_ack    = 1'b1;
        tick();
        ack_seen       = bus.req_ack;
        err_seen       = bus.req_err;
        bus.req_ren    = bus.req_ren  & ~drop_mask;
        bus.req_wen    = bus.req_wen  & ~drop_mask;
        bus.req_lock   = bus.req_lock & ~drop_mask;
        tick();
        ack_next       = bus.req_ack;
        bus.mem_ack    = 1'b0;
        bus.mem_data_o = '0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        bus.req_ren = 3'b111;
        tick();
        tick();
        checks++; if ({bus.mem_ren, bus.mem_wen, bus.busy, bus.req_err} !== 4'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 0000", {bus.mem_ren, bus.mem_wen, bus.busy, bus.req_err}); end
        checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d want 0", bus.grant_id); end
        checks++; if (bus.req_ack !== 3'b000) begin errors++; $display("FAIL reset_ack: got %b want 000", bus.req_ack); end
        checks++; if ({bus.mem_addr, bus.mem_data_i, bus.req_rdata} !== 96'h0) begin errors++; $display("FAIL reset_data: got %h want 0", {bus.mem_addr, bus.mem_data_i, bus.req_rdata}); end
        clear_inputs();
        rst = 1'b1;
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy got %b want 0", bus.busy); end
    endtask

    task automatic test_single_read();
        set_req(2'd1, 32'h8000_1000, 32'h0);
        bus.req_ren[1] = 1'b1;
        tick();
        checks++; if ({bus.mem_ren, bus.mem_wen} !== 2'b10) begin errors++; $display("FAIL rd_strobe: got %b want 10", {bus.mem_ren, bus.mem_wen}); end
        checks++; if (bus.mem_addr !== 32'h8000_1000) begin errors++; $display("FAIL rd_addr: got %h want 80001000", bus.mem_addr); end
        checks++; if (bus.grant_id !== 2'd1) begin errors++; $display("FAIL rd_grant: got %0d want 1", bus.grant_id); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rd_busy: got %b want 1", bus.busy); end
        tick();
        tick();
        tick();
        checks++; if ({bus.mem_ren, bus.req_ack} !== 4'b1000) begin errors++; $display("FAIL rd_hold: got %b want 1000", {bus.mem_ren, bus.req_ack}); end
        bus.mem_data_o = 32'h1234_5678;
        bus.mem_ack    = 1'b1;
        tick();
        checks++; if (bus.req_ack !== 3'b010) begin errors++; $display("FAIL rd_ack: got %b want 010", bus.req_ack); end
        checks++; if (bus.req_rdata !== 32'h1234_5678) begin errors++; $display("FAIL rd_data: got %h want 12345678", bus.req_rdata); end
        checks++; if ({bus.mem_ren, bus.req_err, bus.busy} !== 3'b001) begin errors++; $display("FAIL rd_release: got %b want 001", {bus.mem_ren, bus.req_err, bus.busy}); end
        bus.req_ren[1] = 1'b0;
        tick();
        checks++; if ({bus.req_ack, bus.busy} !== 4'b0001) begin errors++; $display("FAIL rd_onepulse: got %b want 0001", {bus.req_ack, bus.busy}); end
        bus.mem_ack    = 1'b0;
        bus.mem_data_o = '0;
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rd_busy_fall: got %b want 0", bus.busy); end
        checks++; if (bus.req_rdata !== 32'h1234_5678) begin errors++; $display("FAIL rd_data_hold: got %h want 12345678", bus.req_rdata); end
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp [4];
        logic [2:0]  want, mask, ack_seen, ack_next;
        logic [31:0] want_addr;
        logic        err_seen;
        bit          ok;
        exp = '{2'd0, 2'd1, 2'd2, 2'd0};
        do_reset();
        set_req(2'd0, 32'h0000_0100, 32'h0);
        set_req(2'd1, 32'h0000_0200, 32'h0);
        set_req(2'd2, 32'h0000_0300, 32'h0);
        bus.req_ren = 3'b111;
        for (int n = 0; n < 4; n++) begin
            wait_strobe(10, ok);
            checks++; if (!ok) begin errors++; $display("FAIL rr_strobe%0d: no strobe within 10 cycles", n); end
            checks++; if (bus.grant_id !== exp[n]) begin errors++; $display("FAIL rr_grant%0d: got %0d want %0d", n, bus.grant_id, exp[n]); end
            want_addr = 32'h100 * (32'(exp[n]) + 32'd1);
            checks++; if (bus.mem_addr !== want_addr) begin errors++; $display("FAIL rr_addr%0d: got %h want %h", n, bus.mem_addr, want_addr); end
            want = 3'b001 << exp[n];
            // requester 0 keeps its request up after its first ack (a fresh request)
            mask = (n == 0) ? 3'b000 : want;
            complete(32'hD000_0000 + 32'(n), mask, ack_seen, err_seen, ack_next);
            checks++; if (ack_seen !== want) begin errors++; $display("FAIL rr_ack%0d: got %b want %b", n, ack_seen, want); end
            checks++; if (ack_next !== 3'b000) begin errors++; $display("FAIL rr_ack_next%0d: got %b want 000", n, ack_next); end
            checks++; if (bus.req_rdata !== 32'hD000_0000 + 32'(n)) begin errors++; $display("FAIL rr_rdata%0d: got %h want %h", n, bus.req_rdata, 32'hD000_0000 + 32'(n)); end
        end
    endtask

    task automatic test_read_wins();
        logic [2:0] ack_seen, ack_next;
        logic       err_seen;
        do_reset();
        set_req(2'd2, 32'h1F80_0000, 32'h0BAD_BEEF);
        bus.req_ren[2] = 1'b1;
        bus.req_wen[2] = 1'b1;
        tick();
        checks++; if ({bus.mem_ren, bus.mem_wen} !== 2'b10) begin errors++; $display("FAIL rw_strobe: got %b want 10", {bus.mem_ren, bus.mem_wen}); end
        checks++; if ({bus.grant_id, bus.mem_addr} !== {2'd2, 32'h1F80_0000}) begin errors++; $display("FAIL rw_grant_addr: got %0d/%h want 2/1f800000", bus.grant_id, bus.mem_addr); end
        complete(32'h5A5A_0003, 3'b100, ack_seen, err_seen, ack_next);
        checks++; if ({ack_seen, err_seen} !== 4'b1000) begin errors++; $display("FAIL rw_ack: got %b want 1000", {ack_seen, err_seen}); end
        checks++; if (bus.req_rdata !== 32'h5A5A_0003) begin errors++; $display("FAIL rw_rdata: got %h want 5a5a0003", bus.req_rdata); end
    endtask

    task automatic test_timeout();
        int wen_cycles;
        int n;
        // last_grant is 2 here, so requester 0 wins; req_rdata still holds 5a5a0003
        set_req(2'd0, 32'hA000_0010, 32'hCAFE_F00D);
        bus.req_wen[0] = 1'b1;
        tick();
        checks++; if ({bus.mem_ren, bus.mem_wen, bus.grant_id} !== 4'b0100) begin errors++; $display("FAIL to_strobe: got %b want 0100", {bus.mem_ren, bus.mem_wen, bus.grant_id}); end
        checks++; if ({bus.mem_addr, bus.mem_data_i} !== {32'hA000_0010, 32'hCAFE_F00D}) begin errors++; $display("FAIL to_bus: got %h want a0000010cafef00d", {bus.mem_addr, bus.mem_data_i}); end
        wen_cycles = 0;
        n = 0;
        while (bus.req_ack === 3'b000 && n < 400) begin
            if (bus.mem_wen) wen_cycles++;
            tick();
            n++;
        end
        // ISSUE cycle k sees watchdog k-1; abort fires in the cycle where it reads 255,
        // so mem_wen is high for 256 cycles before the ack pulse appears
        checks++; if ({bus.req_ack, bus.req_err} !== 4'b0011) begin errors++; $display("FAIL to_ack_err: got %b want 0011", {bus.req_ack, bus.req_err}); end
        checks++; if (wen_cycles !== TIMEOUT + 1) begin errors++; $display("FAIL to_cycles: got %0d want %0d", wen_cycles, TIMEOUT + 1); end
        checks++; if (bus.req_rdata !== 32'h0) begin errors++; $display("FAIL to_rdata: got %h want 0", bus.req_rdata); end
        checks++; if (bus.mem_wen !== 1'b0) begin errors++; $display("FAIL to_wen: got %b want 0", bus.mem_wen); end
        bus.req_wen[0] = 1'b0;
        tick();
        checks++; if ({bus.req_ack, bus.req_err, bus.busy} !== 5'b0) begin errors++; $display("FAIL to_after: got %b want 00000", {bus.req_ack, bus.req_err, bus.busy}); end
    endtask

    task automatic test_async_reset();
        logic [2:0] ack_seen, ack_next;
        logic       err_seen;
        bit         ok;
        // last_grant is 0 now: without reset requester 1 would beat requester 0
        set_req(2'd1, 32'h0000_4000, 32'h0);
        bus.req_ren[1] = 1'b1;
        tick();
        checks++; if ({bus.mem_ren, bus.grant_id} !== 3'b101) begin errors++; $display("FAIL ar_issue: got %b want 101", {bus.mem_ren, bus.grant_id}); end
        #2 rst = 1'b0;
        #1;
        checks++; if (bus.mem_ren !== 1'b0) begin errors++; $display("FAIL ar_ren: got %b want 0", bus.mem_ren); end
        checks++; if ({bus.busy, bus.grant_id, bus.req_ack, bus.req_err, bus.mem_addr} !== 39'h0) begin errors++; $display("FAIL ar_outputs: got %h want 0", {bus.busy, bus.grant_id, bus.req_ack, bus.req_err, bus.mem_addr}); end
        tick();
        set_req(2'd0, 32'h0000_3000, 32'h0);
        bus.req_ren = 3'b011;
        tick();
        checks++; if (bus.req_ack !== 3'b000) begin errors++; $display("FAIL ar_noack: got %b want 000", bus.req_ack); end
        rst = 1'b1;
        tick();
        checks++; if ({bus.mem_ren, bus.grant_id, bus.mem_addr} !== {1'b1, 2'd0, 32'h0000_3000}) begin errors++; $display("FAIL ar_prio: got %b/%0d/%h want 1/0/00003000", bus.mem_ren, bus.grant_id, bus.mem_addr); end
        complete(32'h0000_0077, 3'b001, ack_seen, err_seen, ack_next);
        checks++; if (ack_seen !== 3'b001) begin errors++; $display("FAIL ar_ack0: got %b want 001", ack_seen); end
        wait_strobe(10, ok);
        checks++; if (!ok || bus.grant_id !== 2'd1) begin errors++; $display("FAIL ar_next: ok %0d grant %0d want 1/1", ok, bus.grant_id); end
        complete(32'h0000_0088, 3'b010, ack_seen, err_seen, ack_next);
        checks++; if (ack_seen !== 3'b010) begin errors++; $display("FAIL ar_ack1: got %b want 010", ack_seen); end
    endtask

    task automatic test_lock();
        logic [1:0] exp [5];
        logic [2:0] want, mask, ack_seen, ack_next;
        logic       err_seen;
        bit         ok;
        int         cnt2;
`ifdef MEM_ARB_LOCK_EN
        exp = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
`else
        exp = '{2'd2, 2'd0, 2'd2, 2'd0, 2'd2};
`endif
        do_reset();
        set_req(2'd2, 32'h0000_2000, 32'h0);
        bus.req_lock[2] = 1'b1;
        bus.req_ren[2]  = 1'b1;
        tick();
        set_req(2'd0, 32'h0000_0100, 32'h0);
        bus.req_ren[0] = 1'b1;
        cnt2 = 0;
        for (int n = 0; n < 5; n++) begin
            wait_strobe(10, ok);
            checks++; if (!ok) begin errors++; $display("FAIL lk_strobe%0d: no strobe within 10 cycles", n); end
            checks++; if (bus.grant_id !== exp[n]) begin errors++; $display("FAIL lk_grant%0d: got %0d want %0d", n, bus.grant_id, exp[n]); end
            if (exp[n] == 2'd2) cnt2++;
            want = 3'b001 << exp[n];
            if (n == 4)        mask = 3'b111;
            else if (cnt2 == 4) mask = 3'b100;
            else               mask = 3'b000;
            complete(32'hB000_0000 + 32'(n), mask, ack_seen, err_seen, ack_next);
            checks++; if (ack_seen !== want) begin errors++; $display("FAIL lk_ack%0d: got %b want %b", n, ack_seen, want); end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_read_wins();
        test_timeout();
        test_async_reset();
        test_lock();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete within 500000 time units");
        $fatal(1, "time limit");
    end

endmodule
